// File: rtl/exec_pkg.sv
// Shared types and sizing for the accumulator execute stage.
// Opcode encoding matches the controller's 3-bit op field.
package exec_pkg;

   localparam int DATA_W    = 8;
   localparam int OP_W      = 3;
   localparam int SHAMT_W   = 3;
   localparam int MUL_STEPS = DATA_W;

   typedef enum logic [OP_W-1:0] {
      ADD   = 3'd0,
      SUB   = 3'd1,
      AND   = 3'd2,
      XOR   = 3'd3,
      SHL   = 3'd4,
      SHR   = 3'd5,
      MULLO = 3'd6,
      MULHI = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      MUL   = 2'd2,
      WB    = 2'd3
   } state_e;

endpackage

// File: rtl/mul_iter.sv
// Sequential WxW shift-add multiplier: done is high W cycles after go, product valid then.
// No backpressure; a go while running restarts the multiply.
module mul_iter #(
   parameter int W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           go,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           done,
   output logic [2*W-1:0] product
);

   localparam int CW = $clog2(W + 1);

   logic [2*W-1:0] mcand;
   logic [W-1:0]   mplier;
   logic [CW-1:0]  cnt;
   logic           run;

   // Bit 0 of b is consumed on the go cycle so the remaining W-1 steps plus the
   // done cycle give exactly W cycles from go to done.
   always_ff @(posedge clk) begin
      if (!reset) begin
         run     <= 1'b0;
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
      end else if (go) begin
         run     <= 1'b1;
         cnt     <= CW'(W - 1);
         mcand   <= {{W{1'b0}}, a} << 1;
         mplier  <= b >> 1;
         product <= b[0] ? {{W{1'b0}}, a} : '0;
      end else if (run) begin
         if (cnt == '0) begin
            run <= 1'b0;
         end else begin
            if (mplier[0]) begin
               product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
         end
      end
   end

   assign done = run && (cnt == '0);

endmodule

// File: rtl/acc_exec_unit.sv
// Execute stage feeding r0: ALU ops in 1 cycle, shifts 1+k cycles, multiplies W+1 cycles.
// busy stalls the controller; start while busy is dropped, no queueing.
module acc_exec_unit
   import exec_pkg::*;
#(
   parameter int W   = 8,
   parameter int OPW = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic [OPW-1:0] op,
   input  logic [W-1:0]   accData,
   input  logic [W-1:0]   opRegData,
   output logic           busy,
   output logic           regWrite,
   output logic [W-1:0]   writeData,
   output logic           carry,
   output logic           zero
);

   state_e               state, state_n;
   op_e                  op_q, op_in;
   logic [W-1:0]         shreg;
   logic [SHAMT_W-1:0]   cnt;
   logic [SHAMT_W-1:0]   k;
   logic                 launch;
   logic                 mul_go, mul_done;
   logic [2*W-1:0]       product;
   logic                 wb_load;
   logic [W-1:0]         wb_data;
   logic                 wb_carry;
   logic [W:0]           add_w, sub_w;
   logic [W-1:0]         sh_val;
   logic                 sh_out;

   assign op_in  = op_e'(op[OP_W-1:0]);
   assign k      = opRegData[SHAMT_W-1:0];
   assign launch = (state == IDLE) && start;
   assign mul_go = launch && ((op_in == MULLO) || (op_in == MULHI));

   // Bit W of the widened difference is the unsigned borrow.
   assign add_w = {1'b0, accData} + {1'b0, opRegData};
   assign sub_w = {1'b0, accData} - {1'b0, opRegData};

   assign busy     = (state != IDLE);
   assign regWrite = (state == WB);

   always_comb begin
      sh_val = {1'b0, shreg[W-1:1]};
      sh_out = shreg[0];
      if (op_q == SHL) begin
         sh_val = {shreg[W-2:0], 1'b0};
         sh_out = shreg[W-1];
      end
   end

   mul_iter #(.W(W)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .go      (mul_go),
      .a       (accData),
      .b       (opRegData),
      .done    (mul_done),
      .product (product)
   );

   always_comb begin
      state_n  = state;
      wb_load  = 1'b0;
      wb_data  = writeData;
      wb_carry = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               unique case (op_in)
                  ADD: begin
                     state_n  = WB;
                     wb_load  = 1'b1;
                     wb_data  = add_w[W-1:0];
                     wb_carry = add_w[W];
                  end
                  SUB: begin
                     state_n  = WB;
                     wb_load  = 1'b1;
                     wb_data  = sub_w[W-1:0];
                     wb_carry = sub_w[W];
                  end
                  AND: begin
                     state_n = WB;
                     wb_load = 1'b1;
                     wb_data = accData & opRegData;
                  end
                  XOR: begin
                     state_n = WB;
                     wb_load = 1'b1;
                     wb_data = accData ^ opRegData;
                  end
                  SHL, SHR: begin
                     if (k == '0) begin
                        state_n = WB;
                        wb_load = 1'b1;
                        wb_data = accData;
                     end else begin
                        state_n = SHIFT;
                     end
                  end
                  default: state_n = MUL;
               endcase
            end
         end
         SHIFT: begin
            // Final shift lands straight in writeData so WB follows without a gap.
            if (cnt == SHAMT_W'(1)) begin
               state_n  = WB;
               wb_load  = 1'b1;
               wb_data  = sh_val;
               wb_carry = sh_out;
            end
         end
         MUL: begin
            if (mul_done) begin
               state_n = WB;
               wb_load = 1'b1;
               if (op_q == MULHI) begin
                  wb_data = product[2*W-1:W];
               end else begin
                  wb_data  = product[W-1:0];
                  wb_carry = |product[2*W-1:W];
               end
            end
         end
         WB:      state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         op_q      <= ADD;
         shreg     <= '0;
         cnt       <= '0;
         writeData <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
      end else begin
         state <= state_n;
         if (launch) begin
            op_q  <= op_in;
            shreg <= accData;
            cnt   <= k;
         end else if (state == SHIFT) begin
            shreg <= sh_val;
            cnt   <= cnt - 1'b1;
         end
         if (wb_load) begin
            writeData <= wb_data;
            carry     <= wb_carry;
            zero      <= (wb_data == '0);
         end
      end
   end

endmodule

// File: doc/acc_exec_unit.md
Name: acc_exec_unit

Overview:
- Execute stage directly upstream of the register file.
- Consumes the accumulator (r0) and operand-register read data, then performs the selected ALU operation.
- Produces the writeback value plus a one-cycle write strobe into r0.
- Simple ops complete in one cycle. Shifts and multiplies are iterative, and a busy signal stalls the controller while they run.

Parameters:
- W, 8, datapath width (must match register width)
- OPW, 3, opcode field width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  launch operation; sampled only in IDLE
- op  in  OPW  operation select, sampled with start
- accData  in  W  current r0 contents
- opRegData  in  W  operand register contents
- busy  out  1  high while an operation is in flight (cycle after start until the writeback cycle, inclusive)
- regWrite  out  1  one-cycle pulse: writeData valid, write r0
- writeData  out  W  result, held stable after the pulse until the next writeback
- carry  out  1  carry/borrow/shift-out flag
- zero  out  1  result == 0 flag

Behaviour:
- Reset (reset==0 at posedge) forces state=IDLE and clears busy, regWrite, writeData, carry and zero to 0. It has priority over start.
- Reset mid-operation aborts the operation with no regWrite; all internal counters and operand latches are cleared.
- Operands are latched on the start cycle (cycle N). Later changes to accData/opRegData have no effect.
- start while busy is ignored: no queueing, no error.
- ops: 0 ADD, 1 SUB (acc-opReg), 2 AND, 3 XOR, 4 SHL, 5 SHR, 6 MULLO, 7 MULHI.
- States: IDLE, SHIFT, MUL, WB.
  - IDLE→WB for ADD/SUB/AND/XOR, and for SHL/SHR with amount 0.
  - IDLE→SHIFT when the shift amount k = opRegData[2:0] is nonzero. SHIFT runs one bit per cycle with a down-counter, then →WB.
  - IDLE→MUL: 8-step shift-add over opReg bits, LSB first, into a 2W-bit product, then →WB.
  - WB: regWrite=1 for exactly one cycle, flags updated, then →IDLE.
- Latency (regWrite high in cycle): single-cycle ops N+1; SHL/SHR N+1+k; MULLO/MULHI N+9. busy=0 in cycle N+latency+1.
- Arithmetic is W-bit modular. Carry rules:
  - ADD: carry = carry-out.
  - SUB: carry = borrow (1 iff acc<opReg, unsigned).
  - AND/XOR: carry = 0.
  - Shifts: carry = last bit shifted out (0 if k=0). SHR is logical, zero fill.
  - MULLO: result = product[W-1:0], carry = (product[2W-1:W]!=0).
  - MULHI: result = product[2W-1:W], carry = 0.
- zero = (result==0). Flags change only in WB.
- Back-to-back operation: start may be asserted in the cycle after WB (busy already 0).

Decomposition:
- Package exec_pkg:
  - op_e enum (ADD..MULHI)
  - state_e enum (IDLE, SHIFT, MUL, WB)
  - constant MUL_STEPS=W
  - width localparams
- One natural sub-module, mul_iter: sequential W×W shift-add multiplier.
  - Ports: clk, reset, go, a, b, done, product.
  - Fixed W-cycle latency; instantiated by acc_exec_unit.

Test Plan:
- ADD acc=0xF0, opReg=0x20, start at N → regWrite pulse at N+1, writeData=0x10, carry=1, zero=0, busy=0 at N+2.
- SUB acc=0x05, opReg=0x05 → writeData=0x00, zero=1, carry=0. SUB acc=0x03, opReg=0x05 → 0xFE, carry=1.
- SHL acc=0x81, opReg=0x03 → regWrite at N+4, writeData=0x08, carry=0. SHR acc=0x81, opReg=0x01 → regWrite at N+2, 0x40, carry=1. SHL opReg=0x08 (k=0) → N+1, 0x81, carry=0.
- MULLO acc=0x12, opReg=0x34 → regWrite at N+9, 0xA8, carry=1. MULHI same operands → 0x03, carry=0. Change accData during busy → result unchanged.
- start pulsed at N+3 during MUL → ignored, single regWrite at N+9. reset low at N+4 of a MUL → busy=0 and flags=0 at N+5, no regWrite ever; a new ADD after reset releases completes normally.
- start and reset low in the same cycle → stays IDLE, no regWrite.
